// File: rtl/minterm_seq_detector_pkg.sv
// Shared definitions for the minterm sequence detector: FSM state type and
// default geometry of the window, truth table and match counter.
package minterm_seq_detector_pkg;

  // FILL: collecting the first WIDTH bits; RUN: every accepted bit is evaluated.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 3;
  localparam logic [7:0]  DEF_MASK  = 8'h46;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/minterm_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; increments are dropped once saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/minterm_seq_detector.sv
// Serial minterm detector: a WIDTH-bit window of the serial stream indexes a
// loadable truth table; each evaluation produces a registered z/z_valid pair
// and bumps a saturating match counter on hits.
module minterm_seq_detector
  import minterm_seq_detector_pkg::*;
#(
  parameter int unsigned             WIDTH = DEF_WIDTH,
  parameter logic [2**WIDTH-1:0]     MASK  = DEF_MASK,
  parameter int unsigned             CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic                 x,
  input  logic                 load_mask,
  input  logic [2**WIDTH-1:0]  mask_in,
  output logic                 z,
  output logic                 z_valid,
  output logic                 primed,
  output logic [CNT_W-1:0]     match_count
);

  // Fill counter only needs to reach WIDTH-1; the WIDTH-th bit moves to RUN.
  localparam int unsigned FW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);

  state_t               state;
  logic [FW-1:0]        fill_cnt;
  logic [WIDTH-1:0]     window;
  logic [WIDTH-1:0]     win_next;
  logic [2**WIDTH-1:0]  mask_reg;
  logic                 eval;
  logic                 hit;

  // Candidate window and evaluation decision for the current cycle; the
  // truth-table lookup uses the mask as it stands before any load this cycle.
  always_comb begin
    win_next = {window[WIDTH-2:0], x};
    eval     = in_valid && !clear && ((state == RUN) || (fill_cnt == FILL_LAST));
    hit      = eval && mask_reg[win_next];
  end

  // FSM, window, mask register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      window   <= '0;
      mask_reg <= MASK;
      z        <= 1'b0;
      z_valid  <= 1'b0;
      primed   <= 1'b0;
    end else begin
      if (load_mask) begin
        mask_reg <= mask_in;
      end
      if (clear) begin
        state    <= FILL;
        fill_cnt <= '0;
        window   <= '0;
        z        <= 1'b0;
        z_valid  <= 1'b0;
        primed   <= 1'b0;
      end else begin
        z_valid <= 1'b0;
        if (in_valid) begin
          window <= win_next;
          unique case (state)
            FILL: begin
              if (fill_cnt == FILL_LAST) begin
                state  <= RUN;
                primed <= 1'b1;
              end else begin
                fill_cnt <= fill_cnt + FW'(1);
              end
            end
            RUN: ;
            default: state <= FILL;
          endcase
        end
        if (eval) begin
          z       <= mask_reg[win_next];
          z_valid <= 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (hit),
    .count (match_count)
  );

endmodule
